// File: rtl/parity_pkg.sv
// Package shared by the parity round-robin scheduler slice.
// Holds the FSM state encoding, the {par, d[3:0]} word layout constants
// and the parity-check helper used by the datapath.
package parity_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACK    = 2'd1,
        CHECK  = 2'd2,
        REPORT = 2'd3
    } state_e;

    localparam int PAR_BIT = 4;
    localparam int DATA_W  = 4;
    localparam int WORD_W  = 5;

    // Returns 1 when the word's parity does not match the expected sense.
    // odd = 0: even parity expected over {par, d}; odd = 1: odd parity expected.
    function automatic logic word_err(input logic [WORD_W-1:0] w, input logic odd);
        return (^w[DATA_W-1:0]) ^ w[PAR_BIT] ^ odd;
    endfunction

endpackage

// File: rtl/parity_rr_sched_if.sv
// Requester/result bus of the parity round-robin scheduler.
// Handshake: a requester holds req_valid[i] and its data slice stable until it
// sees req_ready[i]; a word transfers on the rising edge where both are high.
// res_valid is a one-cycle strobe; res_id/res_err stay valid until the next one.
//   req_valid  N_REQ         per-requester word valid
//   req_data   5*N_REQ       requester i at [5i+4:5i] = {par, d[3:0]}
//   req_ready  N_REQ         one-hot accept
//   res_valid  1             result strobe
//   res_id     $clog2(N_REQ) requester ID of the result
//   res_err    1             1 = parity mismatch
// master: requester/consumer side; slave: scheduler side.
interface parity_rr_sched_if #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
);
    logic [N_REQ-1:0]                   req_valid;
    logic [parity_pkg::WORD_W*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]                   req_ready;
    logic                               res_valid;
    logic [ID_W-1:0]                    res_id;
    logic                               res_err;

    modport master (
        output req_valid, req_data,
        input  req_ready, res_valid, res_id, res_err
    );

    modport slave (
        input  req_valid, req_data,
        output req_ready, res_valid, res_id, res_err
    );
endinterface

// File: rtl/parity_rr_sched_rr_arbiter.sv
// Combinational round-robin arbiter.
// Picks the first asserted request at or after ptr, wrapping N_REQ-1 -> 0.
//   req      in  N_REQ  request vector
//   ptr      in  ID_W   highest-priority index
//   gnt      out N_REQ  one-hot grant (all zero when no request)
//   gnt_idx  out ID_W   index of the granted requester
//   gnt_any  out 1      at least one request present
module rr_arbiter #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] ptr,
    output logic [N_REQ-1:0]         gnt,
    output logic [$clog2(N_REQ)-1:0] gnt_idx,
    output logic                     gnt_any
);
    localparam int ID_W = $clog2(N_REQ);

    logic [ID_W:0]   sum;
    logic [ID_W-1:0] idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        sum     = '0;
        idx     = '0;
        for (int i = 0; i < N_REQ; i++) begin
            // One extra bit holds ptr+i before the modulo-N_REQ wrap.
            sum = {1'b0, ptr} + (ID_W+1)'(i);
            if (sum >= (ID_W+1)'(N_REQ)) begin
                sum = sum - (ID_W+1)'(N_REQ);
            end
            idx = sum[ID_W-1:0];
            if (!gnt_any && req[idx]) begin
                gnt_any  = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
            end
        end
    end
endmodule

// File: rtl/parity_rr_sched.sv
// Round-robin scheduler sharing one 4-bit parity checker between N_REQ
// nibble requesters. One word is granted, accepted, checked and reported at
// a time (IDLE -> ACK -> CHECK -> REPORT), so at most one word per 4 cycles.
// Optional feature macro: PARITY_ERRCNT_EN builds the saturating error
// counter and its clear; without it err_cnt is tied to 0 and err_clr ignored.
//   clk, rst_n  clock, synchronous active-low reset
//   bus         requester/result bus (slave side)
//   err_clr     clear error counter (wins over a same-cycle increment)
//   err_cnt     mismatches since reset/clear, saturating
//   led         active-low LED, 0 = last result was an error
//   dbg_state   current FSM state
module parity_rr_sched
    import parity_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int CNT_W   = 8,
    parameter bit ODD_PAR = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    parity_rr_sched_if.slave bus,
    input  logic             err_clr,
    output logic [CNT_W-1:0] err_cnt,
    output logic             led,
    output state_e           dbg_state
);
    localparam int ID_W = $clog2(N_REQ);

    state_e            state, state_d;
    logic [ID_W-1:0]   gnt_id, ptr, res_id_q, arb_idx;
    logic [N_REQ-1:0]  ready_q, arb_gnt;
    logic              arb_any;
    logic [WORD_W-1:0] word_q;
    logic              err_q, res_valid_q, led_q;
    logic [WORD_W-1:0] words [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_words
        assign words[g] = bus.req_data[g*WORD_W +: WORD_W];
    end

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req     (bus.req_valid),
        .ptr     (ptr),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx),
        .gnt_any (arb_any)
    );

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (arb_any) state_d = ACK;
            // A requester that dropped valid during its ready cycle forfeits the grant.
            ACK:     state_d = bus.req_valid[gnt_id] ? CHECK : IDLE;
            CHECK:   state_d = REPORT;
            REPORT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            gnt_id      <= '0;
            ptr         <= '0;
            ready_q     <= '0;
            word_q      <= '0;
            err_q       <= 1'b0;
            res_id_q    <= '0;
            res_valid_q <= 1'b0;
            led_q       <= 1'b1;
        end else begin
            state       <= state_d;
            ready_q     <= '0;
            res_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (arb_any) begin
                        gnt_id  <= arb_idx;
                        ready_q <= arb_gnt;  // high only during ACK
                    end
                end
                ACK: begin
                    if (bus.req_valid[gnt_id]) word_q <= words[gnt_id];
                end
                CHECK: begin
                    // Result registers load here so they are presented in REPORT
                    // and then hold until the next result.
                    err_q       <= word_err(word_q, ODD_PAR);
                    res_id_q    <= gnt_id;
                    res_valid_q <= 1'b1;
                end
                REPORT: begin
                    led_q <= ~err_q;
                    ptr   <= (gnt_id == ID_W'(N_REQ-1)) ? '0 : gnt_id + 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef PARITY_ERRCNT_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (err_clr) begin
            cnt_q <= '0;
        end else if (state == REPORT && err_q && cnt_q != '1) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign err_cnt = cnt_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign err_cnt        = '0;
`endif

    assign bus.req_ready = ready_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_id    = res_id_q;
    assign bus.res_err   = err_q;
    assign led           = led_q;
    assign dbg_state     = state;
endmodule

// File: tb/tb_parity_rr_sched.sv
module tb_parity_rr_sched;
    import parity_pkg::*;

    localparam int N_REQ = 4;
    localparam int CNT_W = 2;
    localparam int ID_W  = $clog2(N_REQ);
    localparam int EW    = ID_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // ---------------- clock / reset ----------------
    logic clk     = 1'b0;
    logic rst_n   = 1'b0;
    logic err_clr = 1'b0;
    always #5 clk = ~clk;

    logic [CNT_W-1:0] err_cnt0, err_cnt1;
    logic             led0, led1;
    state_e           st0, st1;

    parity_rr_sched_if #(.N_REQ(N_REQ)) bus0 ();
    parity_rr_sched_if #(.N_REQ(N_REQ)) bus1 ();
    assign bus1.req_valid = bus0.req_valid;
    assign bus1.req_data  = bus0.req_data;

    parity_rr_sched #(.N_REQ(N_REQ), .CNT_W(CNT_W), .ODD_PAR(1'b0)) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(bus0.slave), .err_clr(err_clr),
        .err_cnt(err_cnt0), .led(led0), .dbg_state(st0)
    );

    parity_rr_sched #(.N_REQ(N_REQ), .CNT_W(CNT_W), .ODD_PAR(1'b1)) u_dut_odd (
        .clk(clk), .rst_n(rst_n), .bus(bus1.slave), .err_clr(err_clr),
        .err_cnt(err_cnt1), .led(led1), .dbg_state(st1)
    );

    // ---------------- scoreboard state ----------------
    logic [EW-1:0]    exp_q[$];
    logic             exp_led0, exp_led1;
    logic [CNT_W-1:0] exp_cnt0, exp_cnt1;
    int               n_chk  = 0;
    int               n_pass = 0;
    logic [WORD_W-1:0] rr_w [N_REQ];

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        exp_led0 = 1'b1;
        exp_led1 = 1'b1;
        exp_cnt0 = '0;
        exp_cnt1 = '0;
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input int id, input logic [WORD_W-1:0] w, input bit push);
        bus0.req_valid[id] = 1'b1;
        bus0.req_data[id*WORD_W +: WORD_W] = w;
        if (push) exp_q.push_back({ID_W'(id), ^w});
    endtask

    task automatic wait_ready(input int id, output int waited);
        logic [N_REQ-1:0] oh;
        oh = '0;
        oh[id] = 1'b1;
        waited = 0;
        do begin
            tick();
            waited++;
            chk("no_stray_res_valid", 32'(bus0.res_valid), 0);
        end while (bus0.req_ready == '0 && waited < 20);
        chk("ready_onehot", 32'(bus0.req_ready), 32'(oh));
        chk("ready_onehot_odd", 32'(bus1.req_ready), 32'(oh));
    endtask

    // Called at the negedge of the ready (ACK) cycle T.
    task automatic check_result(input logic [N_REQ-1:0] drop, input bit clr);
        logic [EW-1:0]   e;
        logic [ID_W-1:0] eid;
        logic            eerr, eerr_n;
        tick();  // T+1
        chk("res_valid_t1", 32'(bus0.res_valid), 0);
        bus0.req_valid = bus0.req_valid & ~drop;
        tick();  // T+2
        if (clr) err_clr = 1'b1;
        chk("res_valid_t2", 32'(bus0.res_valid), 1);
        chk("res_valid_t2_odd", 32'(bus1.res_valid), 1);
        if (exp_q.size() == 0) begin
            n_chk++;
            $error("FAIL exp_q_empty: observed result expected none");
            e = '0;
        end else begin
            e = exp_q.pop_front();
        end
        {eid, eerr} = e;
        eerr_n = ~eerr;
        chk("res_id", 32'(bus0.res_id), 32'(eid));
        chk("res_err", 32'(bus0.res_err), 32'(eerr));
        chk("res_id_odd", 32'(bus1.res_id), 32'(eid));
        chk("res_err_odd", 32'(bus1.res_err), 32'(eerr_n));
        exp_led0 = eerr_n;
        exp_led1 = eerr;
`ifdef PARITY_ERRCNT_EN
        if (clr) begin
            exp_cnt0 = '0;
            exp_cnt1 = '0;
        end else begin
            if (eerr && exp_cnt0 != CNT_MAX) exp_cnt0++;
            if (eerr_n && exp_cnt1 != CNT_MAX) exp_cnt1++;
        end
`endif
        tick();  // T+3
        err_clr = 1'b0;
        chk("res_valid_t3", 32'(bus0.res_valid), 0);
        chk("res_id_hold", 32'(bus0.res_id), 32'(eid));
        chk("res_err_hold", 32'(bus0.res_err), 32'(eerr));
        chk("led", 32'(led0), 32'(exp_led0));
        chk("led_odd", 32'(led1), 32'(exp_led1));
        chk("err_cnt", 32'(err_cnt0), 32'(exp_cnt0));
        chk("err_cnt_odd", 32'(err_cnt1), 32'(exp_cnt1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int waited;
        int cnt_tbl [5];
        cnt_tbl = '{1, 2, 3, 3, 3};
        model_reset();
        bus0.req_valid = '1;
        bus0.req_data  = 20'h5A3C1;

        // Reset held 3 cycles with all requesters valid
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_ready", 32'(bus0.req_ready), 0);
            chk("rst_res_valid", 32'(bus0.res_valid), 0);
            chk("rst_led", 32'(led0), 1);
            chk("rst_err_cnt", 32'(err_cnt0), 0);
            chk("rst_state", 32'(st0), 32'(IDLE));
            chk("rst_res_id", 32'(bus0.res_id), 0);
            chk("rst_res_err", 32'(bus0.res_err), 0);
        end
        bus0.req_valid = '0;
        bus0.req_data  = '0;
        rst_n = 1'b1;

        // Single word from requester 2: good then bad parity
        drive(2, 5'b1_0111, 1'b1);
        wait_ready(2, waited);
        chk("first_grant_latency", 32'(waited), 1);
        check_result(4'b0100, 1'b0);
        drive(2, 5'b0_0111, 1'b1);
        wait_ready(2, waited);
        check_result(4'b0100, 1'b0);

        // Round-robin from a freshly reset pointer
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        model_reset();
        chk("rst_pulse_led", 32'(led0), 1);
        for (int i = 0; i < N_REQ; i++) begin
            rr_w[i] = WORD_W'($urandom_range(0, 31));
            drive(i, rr_w[i], 1'b0);
        end
        for (int k = 0; k < 5; k++) exp_q.push_back({ID_W'(k % N_REQ), ^rr_w[k % N_REQ]});
        for (int k = 0; k < 5; k++) begin
            wait_ready(k % N_REQ, waited);
            chk("grant_gap", 32'(waited), 1);
            check_result((k == 4) ? '1 : '0, 1'b0);
        end

        // Withdraw: requester 1 drops valid in its ready cycle
        drive(1, 5'b0_0011, 1'b0);
        wait_ready(1, waited);
        bus0.req_valid[1] = 1'b0;
        tick();
        chk("withdraw_no_res", 32'(bus0.res_valid), 0);
        chk("withdraw_idle", 32'(st0), 32'(IDLE));
        tick();
        chk("withdraw_no_res2", 32'(bus0.res_valid), 0);
        drive(1, 5'b1_0011, 1'b1);
        drive(3, 5'b0_1110, 1'b1);
        wait_ready(1, waited);
        check_result(4'b0010, 1'b0);
        wait_ready(3, waited);
        check_result(4'b1000, 1'b0);

        // Counter: clear, saturate, clear during a bad REPORT
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
`ifdef PARITY_ERRCNT_EN
        exp_cnt0 = '0;
        exp_cnt1 = '0;
`endif
        chk("err_clr", 32'(err_cnt0), 0);
        for (int k = 0; k < 5; k++) begin
            drive(0, 5'b0_0001, 1'b1);
            wait_ready(0, waited);
            check_result(4'b0001, 1'b0);
`ifdef PARITY_ERRCNT_EN
            chk("cnt_seq", 32'(err_cnt0), 32'(cnt_tbl[k]));
`endif
        end
        drive(0, 5'b1_0000, 1'b1);
        wait_ready(0, waited);
        check_result(4'b0001, 1'b1);

        // Mid-operation reset while in CHECK
        drive(2, 5'b0_0101, 1'b0);
        wait_ready(2, waited);
        tick();
        chk("midrst_in_check", 32'(st0), 32'(CHECK));
        rst_n = 1'b0;
        tick();
        chk("midrst_no_res", 32'(bus0.res_valid), 0);
        chk("midrst_idle", 32'(st0), 32'(IDLE));
        chk("midrst_ready", 32'(bus0.req_ready), 0);
        chk("midrst_led", 32'(led0), 1);
        chk("midrst_cnt", 32'(err_cnt0), 0);
        model_reset();
        rst_n = 1'b1;
        bus0.req_valid[2] = 1'b0;
        tick();
        chk("midrst_no_res2", 32'(bus0.res_valid), 0);
        drive(0, 5'b1_1001, 1'b1);
        drive(1, 5'b1_1000, 1'b1);
        wait_ready(0, waited);
        check_result(4'b0001, 1'b0);
        wait_ready(1, waited);
        check_result(4'b0010, 1'b0);

        chk("exp_q_drained", 32'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
